// File: rtl/uart_cmd_if.sv
// uart_cmd_if: serialises register-access commands (R/W + address + data)
// into UART TX bytes, MSB first, and assembles read responses from UART RX
// bytes into a read word.
// Optional feature: define UART_CMD_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES clocks without a received byte (pulses read_timeout).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle, and cmd/cmd_valid
// are not looked at otherwise. tx_en/tx_done, rx_done, read_valid and
// read_timeout are single-cycle pulses with no back-pressure.
module uart_cmd_if #(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [8*ADDR_BYTES+8*DATA_BYTES-1:0]   cmd,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  output logic [8*DATA_BYTES-1:0]                read_data,
  output logic                                   read_valid,
  output logic                                   read_timeout,
  output logic [7:0]                             tx_data,
  output logic                                   tx_en,
  input  logic                                   tx_done,
  input  logic [7:0]                             rx_data,
  input  logic                                   rx_done
);

  localparam int CMD_W  = 8*ADDR_BYTES + 8*DATA_BYTES;
  localparam int DATA_W = 8*DATA_BYTES;
  localparam int CNT_W  = $clog2(ADDR_BYTES + DATA_BYTES + 1);

  localparam logic [CNT_W-1:0] HDR_CNT = CNT_W'(ADDR_BYTES);
  localparam logic [CNT_W-1:0] ALL_CNT = CNT_W'(ADDR_BYTES + DATA_BYTES);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_REQ  = 2'd1,
    SEND_WAIT = 2'd2,
    RECV      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CMD_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               rw_q, rw_d;
  logic [DATA_W-1:0]  asm_q, asm_d;
  logic [DATA_W-1:0]  read_data_q, read_data_d;
  logic               read_valid_q, read_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;

  // Helpers: next byte counter, shifted command, and assembly with the new RX byte.
  logic [CNT_W-1:0]   cnt_inc;
  logic [CMD_W-1:0]   shift_nxt;
  logic [DATA_W+7:0]  asm_cat;
  logic [DATA_W-1:0]  asm_nxt;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign shift_nxt = shift_q << 8;
  assign asm_cat   = {asm_q, rx_data};
  assign asm_nxt   = asm_cat[DATA_W-1:0];

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] tmo_q, tmo_d;
  logic        read_timeout_q, read_timeout_d;
`else
  // Timeout disabled: the parameter only exists for interface compatibility.
  logic [23:0] unused_tmo;
  assign unused_tmo = 24'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic for the command FSM.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    rw_d         = rw_q;
    asm_d        = asm_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    cmd_ready_d  = 1'b0;
    tx_data_d    = tx_data_q;
    tx_en_d      = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    tmo_d          = tmo_q;
    read_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready_q gates acceptance so nothing is taken while it is still low after reset.
        if (cmd_valid && cmd_ready_q) begin
          shift_d   = cmd;
          cnt_d     = '0;
          rw_d      = cmd[CMD_W-1];
          total_d   = cmd[CMD_W-1] ? ALL_CNT : HDR_CNT;
          tx_data_d = cmd[CMD_W-1 -: 8];
          tx_en_d   = 1'b1;
          state_d   = SEND_REQ;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      SEND_REQ, SEND_WAIT: begin
        // A tx_done coincident with tx_en (SEND_REQ) counts for the byte just started.
        if (state_q == SEND_REQ) state_d = SEND_WAIT;
        if (tx_done) begin
          shift_d = shift_nxt;
          cnt_d   = cnt_inc;
          if (cnt_inc != total_q) begin
            tx_data_d = shift_nxt[CMD_W-1 -: 8];
            tx_en_d   = 1'b1;
            state_d   = SEND_REQ;
          end else if (rw_q) begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = RECV;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      RECV: begin
        if (rx_done) begin
          asm_d = asm_nxt;
          cnt_d = cnt_inc;
`ifdef UART_CMD_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (cnt_q == RD_LAST) begin
            read_data_d  = asm_nxt;
            read_valid_d = 1'b1;
            cmd_ready_d  = 1'b1;
            state_d      = IDLE;
          end
        end
`ifdef UART_CMD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          read_timeout_d = 1'b1;
          cmd_ready_d    = 1'b1;
          state_d        = IDLE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
`endif
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      total_q      <= '0;
      rw_q         <= 1'b0;
      asm_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      rw_q         <= rw_d;
      asm_q        <= asm_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  // Read inactivity counter and timeout pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q          <= '0;
      read_timeout_q <= 1'b0;
    end else begin
      tmo_q          <= tmo_d;
      read_timeout_q <= read_timeout_d;
    end
  end
  assign read_timeout = read_timeout_q;
`else
  assign read_timeout = 1'b0;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;

endmodule
